// File: rtl/seg7_ascii_pkg.sv
// Shared definitions for the 7-segment reverse path: segment bit order,
// settle FSM states and the canonical pattern-to-ASCII map.
package seg7_ascii_pkg;

    // Segment bit order shared with the forward decoder: bit0 = a ... bit6 = g.
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_bits_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOCKED
    } settle_state_t;

    typedef struct packed {
        logic [6:0] pat;
        logic [6:0] ascii;
    } rev_map_t;

    localparam logic [6:0] UNK_CHAR  = 7'h3F;
    localparam int         REV_MAP_N = 31;

    // 7'h27 and 7'h67 are the alternate '7' and '9' glyphs some decoders emit.
    localparam rev_map_t REV_MAP [REV_MAP_N] = '{
        '{7'h3F, 7'h30}, '{7'h06, 7'h31}, '{7'h5B, 7'h32}, '{7'h4F, 7'h33},
        '{7'h66, 7'h34}, '{7'h6D, 7'h35}, '{7'h7D, 7'h36}, '{7'h07, 7'h37},
        '{7'h27, 7'h37}, '{7'h7F, 7'h38}, '{7'h6F, 7'h39}, '{7'h67, 7'h39},
        '{7'h77, 7'h41}, '{7'h7C, 7'h42}, '{7'h39, 7'h43}, '{7'h5E, 7'h44},
        '{7'h79, 7'h45}, '{7'h71, 7'h46}, '{7'h3D, 7'h47}, '{7'h76, 7'h48},
        '{7'h1E, 7'h4A}, '{7'h38, 7'h4C}, '{7'h37, 7'h4E}, '{7'h73, 7'h50},
        '{7'h31, 7'h52}, '{7'h3E, 7'h55}, '{7'h6E, 7'h59},
        '{7'h40, 7'h2D}, '{7'h08, 7'h5F}, '{7'h48, 7'h3D}, '{7'h00, 7'h20}
    };

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse map: normalized (active-high) segment pattern to
// ASCII, flagging patterns with no canonical glyph.
module seg7_pattern_lookup
    import seg7_ascii_pkg::*;
(
    input  seg_bits_t  i_pat,
    output logic [6:0] o_ascii,
    output logic       o_unk
);

    always_comb begin
        // NOTE: every output gets a default before the search loop; a path that
        // leaves an output unassigned in always_comb would infer a latch.
        o_ascii = UNK_CHAR;
        o_unk   = 1'b1;
        for (int i = 0; i < REV_MAP_N; i++) begin
            if (i_pat == REV_MAP[i].pat) begin
                o_ascii = REV_MAP[i].ascii;
                o_unk   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_ascii_reader.sv
// Samples a multiplexed 7-segment bus, waits for each digit to settle and
// queues changed characters as {idx, ascii, unk} behind a valid/ready port.
module seg7_ascii_reader
    import seg7_ascii_pkg::*;
#(
    parameter  int DIGITS = 4,
    parameter  int STABLE = 4,
    parameter  int DEPTH  = 4,
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              AL,
    input  logic [6:0]        SEG,
    input  logic [DIGITS-1:0] DIG,
    input  logic              READY,
    input  logic              CLR,
    output logic              VALID,
    output logic [6:0]        D,
    output logic [IW-1:0]     IDX,
    output logic              UNK,
    output logic              OVF
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [6:0]    ascii;
        logic          unk;
    } entry_t;

    logic [6:0]    w_pat;
    logic          w_onehot;
    logic [IW-1:0] w_dig_idx;
    logic          w_same;
    logic [7:0]    w_cnt_inc;

    settle_state_t     r_state;
    logic [7:0]        r_cnt;
    logic [DIGITS-1:0] r_dig;
    logic [6:0]        r_pat;
    logic              r_acc;
    logic [IW-1:0]     r_acc_idx;
    logic [6:0]        r_acc_pat;

    assign w_pat     = SEG ^ {7{~AL}};
    assign w_onehot  = $onehot(DIG);
    assign w_same    = (DIG == r_dig) && (w_pat == r_pat);
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_comb begin
        w_dig_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (DIG[i]) w_dig_idx = IW'(i);
        end
    end

    // Acceptance is a one-cycle pulse; the FIFO push happens on the next cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_dig     <= '0;
            r_pat     <= 7'd0;
            r_acc     <= 1'b0;
            r_acc_idx <= '0;
            r_acc_pat <= 7'd0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // reads pre-edge values regardless of statement order.
            r_acc <= 1'b0;
            if (!EN || !w_onehot) begin
                r_state <= ST_IDLE;
                r_cnt   <= 8'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_dig   <= DIG;
                        r_pat   <= w_pat;
                        r_cnt   <= 8'd1;
                        r_state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (w_same) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == 8'(STABLE)) begin
                                r_state   <= ST_LOCKED;
                                r_acc     <= 1'b1;
                                r_acc_idx <= w_dig_idx;
                                r_acc_pat <= r_pat;
                            end
                        end else begin
                            r_dig <= DIG;
                            r_pat <= w_pat;
                            r_cnt <= 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_same) begin
                            r_cnt <= w_cnt_inc;
                        end else begin
                            r_dig   <= DIG;
                            r_pat   <= w_pat;
                            r_cnt   <= 8'd1;
                            r_state <= ST_SETTLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    logic [6:0]  w_ascii;
    logic        w_unk;
    logic        w_new;
    logic        w_push;
    entry_t      w_entry;

    logic [DIGITS-1:0] r_seen;
    logic [6:0]        r_last [DIGITS];

    seg7_pattern_lookup u_lookup (
        .i_pat   (r_acc_pat),
        .o_ascii (w_ascii),
        .o_unk   (w_unk)
    );

    assign w_new   = !r_seen[r_acc_idx] || (r_last[r_acc_idx] != r_acc_pat);
    assign w_push  = r_acc && w_new;
    assign w_entry = '{idx: r_acc_idx, ascii: w_ascii, unk: w_unk};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_seen <= '0;
        end else if (r_acc) begin
            r_seen[r_acc_idx] <= 1'b1;
        end
    end

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic [6:0]    r_d;
    logic [IW-1:0] r_idx;
    logic          r_unk;
    logic          r_ovf;

    logic          w_pop;
    logic          w_full;
    logic          w_push_ok;
    logic          w_drop;
    logic [CW-1:0] w_count_n;
    logic [PW-1:0] w_rd_n;
    entry_t        w_head_n;

    assign w_pop     = r_valid && READY;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_count_n = r_count + CW'(w_push_ok) - CW'(w_pop);
    assign w_rd_n    = r_rd + PW'(w_pop);
    // The next head is the entry being written only when it lands in the head slot.
    assign w_head_n  = (w_push_ok && (r_wr == w_rd_n)) ? w_entry : r_mem[w_rd_n];

    // NOTE: FIFO storage and the last-pattern table carry no reset; they are
    // only read behind r_count and r_seen, which are reset.
    always_ff @(posedge CLK) begin
        if (w_push_ok) r_mem[r_wr] <= w_entry;
        if (r_acc)     r_last[r_acc_idx] <= r_acc_pat;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_d     <= 7'd0;
            r_idx   <= '0;
            r_unk   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + PW'(1);
            r_rd    <= w_rd_n;
            r_count <= w_count_n;
            r_valid <= (w_count_n != '0);
            if (w_count_n != '0) begin
                r_d   <= w_head_n.ascii;
                r_idx <= w_head_n.idx;
                r_unk <= w_head_n.unk;
            end else begin
                r_d   <= 7'd0;
                r_idx <= '0;
                r_unk <= 1'b0;
            end
            if (w_drop)   r_ovf <= 1'b1;
            else if (CLR) r_ovf <= 1'b0;
        end
    end

    assign VALID = r_valid;
    assign D     = r_d;
    assign IDX   = r_idx;
    assign UNK   = r_unk;
    assign OVF   = r_ovf;

endmodule
